pu_accum_result_queue: RTL
==========================

// Module: pu_accum_result_queue
// PURPOSE
//   Result buffer directly downstream of pu_accum. Captures each accumulator
//   result (data + attr) when pu_accum drives it, holds up to DEPTH results,
//   and re-drives the oldest one onto the shared OR-bus when the control
//   unit asserts signal_oe. Decouples the accumulator's output timing from
//   bus-slot scheduling.
// PARAMETERS
//   DATA_WIDTH   32  width of result data word
//   ATTR_WIDTH   4   width of attribute word travelling with the data
//   DEPTH        4   number of result slots (power of 2, >= 2)
//   INVALID_BIT  0   attr bit index set on underflow reads
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   rst           in   1           asynchronous, active-high reset
//   signal_push   in   1           capture data_in/attr_in this cycle
//   data_in       in   DATA_WIDTH  result from pu_accum data_out
//   attr_in       in   ATTR_WIDTH  attributes from pu_accum (overflow etc.)
//   signal_oe     in   1           drive head entry on bus and pop it
//   signal_clear  in   1           synchronous flush of all entries
//   data_out      out  DATA_WIDTH  head data when signal_oe, else 0
//   attr_out      out  ATTR_WIDTH  head attr when signal_oe, else 0
//   full          out  1           count == DEPTH
//   empty         out  1           count == 0
//   count         out  $clog2(DEPTH)+1  occupied slots
//   err_overflow  out  1           sticky: push attempted while full
//   err_underflow out  1           sticky: oe attempted while empty
// BEHAVIOUR
//   - Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//     err_* = 0; storage contents don't-care. Reset mid-operation discards
//     all entries; first push after release goes to slot 0.
//   - Bus rule: data_out/attr_out are combinational from head slot and
//     forced to all-zero whenever signal_oe=0 (wired-OR bus, never float).
//   - Read latency 0: head visible in the same cycle signal_oe is high; pop
//     (rd_ptr+1, mod DEPTH) takes effect at that cycle's rising edge.
//   - Push: on rising edge with signal_push=1 and not full, store
//     {attr_in,data_in} at wr_ptr, wr_ptr+1 mod DEPTH. Pushed value first
//     readable on the cycle after the edge (no same-cycle bypass).
//   - Push while full and no pop: entry dropped, contents unchanged,
//     err_overflow set at that edge.
//   - Push and oe together while full: both happen, count stays DEPTH.
//   - oe while empty: data_out=0, attr_out has only INVALID_BIT=1,
//     err_underflow set, pointers unchanged. A simultaneous push still
//     stores its entry (count 0->1).
//   - Push and oe together, non-empty, non-full: count unchanged.
//   - signal_clear=1: at edge pointers/count -> 0; overrides push and pop
//     that cycle; also clears err_* flags. data_out still shows head while
//     signal_oe=1 in the clear cycle.
//   - err_* flags clear only on rst or signal_clear.
//   - count/full/empty are registered, updated at the same edge as ptrs.
//   - Pointers wrap mod DEPTH; full/empty derived from count, not ptrs.
// TESTING
//   1 rst, push 3/attr 0 then 5/attr 1 -> count=2; oe 2 cycles -> data_out
//     3 then 5, attr_out 0 then 1, empty=1; data_out=0 when oe=0.
//   2 push 1..4 (DEPTH=4) -> full=1; push 9 -> dropped, err_overflow=1;
//     oe x4 -> 1,2,3,4 in order.
//   3 full, push 7 + oe same cycle -> out 1, count stays 4; drain ->
//     2,3,4,7 (wrap-around of both pointers).
//   4 empty, oe=1 -> data_out=0, attr_out=4'b0001, err_underflow=1;
//     same cycle push 6 -> next cycle count=1, oe gives 6.
//   5 push 2 values, assert rst between clock edges -> empty=1, count=0
//     immediately, err_*=0; push 8 then oe -> 8.
//   6 count=3, signal_clear with push+oe -> count=0, err_*=0, no entry kept.

Source files
------------

// File: rtl/pu_accum_result_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : pu_accum_result_queue_if
// Purpose : Handshake/bus bundle between the control unit and the result queue
// Revision: 1.0 - initial release
// ============================================================================
interface pu_accum_result_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int DEPTH      = 4
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic                  signal_push;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ATTR_WIDTH-1:0] attr_in;
  logic                  signal_oe;
  logic                  signal_clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ATTR_WIDTH-1:0] attr_out;
  logic                  full;
  logic                  empty;
  logic [c_CNT_W-1:0]    count;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output signal_push, data_in, attr_in, signal_oe, signal_clear,
    input  data_out, attr_out, full, empty, count, err_overflow, err_underflow
  );

  modport slave (
    input  signal_push, data_in, attr_in, signal_oe, signal_clear,
    output data_out, attr_out, full, empty, count, err_overflow, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/pu_accum_result_queue.sv
`default_nettype none
// ============================================================================
// Module  : pu_accum_result_queue
// Purpose : DEPTH-entry result FIFO that re-drives its head onto a wired-OR bus
// Revision: 1.0 - initial release
// ============================================================================
module pu_accum_result_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int ATTR_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int INVALID_BIT = 0
) (
  input  wire logic clk,
  input  wire logic rst,
  pu_accum_result_queue_if.slave bus
);
  localparam int c_PTR_W   = $clog2(DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_ENTRY_W = ATTR_WIDTH + DATA_WIDTH;

  logic [c_ENTRY_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_err_overflow;
  logic                  r_err_underflow;

  logic                  w_pop;
  logic                  w_push;
  logic [c_CNT_W-1:0]    w_count_nxt;
  logic [c_ENTRY_W-1:0]  w_head;
  logic [DATA_WIDTH-1:0] w_data_out;
  logic [ATTR_WIDTH-1:0] w_attr_out;

  // A pop while full frees a slot at the same edge, so a push may proceed.
  assign w_pop  = bus.signal_oe & ~r_empty;
  assign w_push = bus.signal_push & (~r_full | w_pop);
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - c_CNT_W'(1);
    end
  end

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push && !bus.signal_clear) begin
      r_mem[r_wr_ptr] <= {bus.attr_in, bus.data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_empty         <= 1'b1;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else if (bus.signal_clear) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_empty         <= 1'b1;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (bus.signal_push && !w_push) begin
        r_err_overflow <= 1'b1;
      end
      if (bus.signal_oe && r_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // Bus must read as zero when not selected; an empty read flags INVALID_BIT.
  always_comb begin
    w_data_out = '0;
    w_attr_out = '0;
    if (bus.signal_oe) begin
      if (r_empty) begin
        w_attr_out[INVALID_BIT] = 1'b1;
      end else begin
        {w_attr_out, w_data_out} = w_head;
      end
    end
  end

  assign bus.data_out      = w_data_out;
  assign bus.attr_out      = w_attr_out;
  assign bus.full          = r_full;
  assign bus.empty         = r_empty;
  assign bus.count         = r_count;
  assign bus.err_overflow  = r_err_overflow;
  assign bus.err_underflow = r_err_underflow;

endmodule
`default_nettype wire
